multi_dataflow_stream_sched: RTL and testbench
==============================================

Name: multi_dataflow_stream_sched

Overview:
- Parametrised N-channel input scheduler between the multi_dataflow streamer and engine; generalises the single inStream0 path to N_CH source streams.
- Merges N_CH valid/ready streams into one engine sink stream.
- Uses round-robin, burst-granular arbitration and per-channel programmed beat counts.
- Tags each beat with its channel, flags each channel's last beat, and pulses done when all enabled channels drain.

Parameters:
N_CH, 2, number of input channels (2..8)
DATA_WIDTH, 32, stream data width in bits
CNT_WIDTH, 16, width of per-channel beat counters
BURST, 4, max consecutive beats granted to one channel per turn (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous soft clear (from ctrl clear)
enable_i  in  1  global enable; low freezes all state
start_i  in  1  one-cycle start pulse; samples len_i, ch_mask_i
len_i  in  N_CH*CNT_WIDTH  beats to transfer per channel
ch_mask_i  in  N_CH  channel enable mask
in_data_i  in  N_CH*DATA_WIDTH  channel data
in_valid_i  in  N_CH  channel valid
in_ready_o  out  N_CH  channel ready
out_data_o  out  DATA_WIDTH  merged data to engine
out_tag_o  out  max(1,$clog2(N_CH))  channel index of out_data_o
out_last_o  out  1  beat is final beat of its channel
out_valid_o  out  1  merged valid
out_ready_i  in  1  engine ready
busy_o  out  1  job in progress
done_o  out  1  one-cycle completion pulse (drives evt)
perf_stall_o  out  32  back-pressure cycle count (optional feature)

Behaviour:
Reset (rst_ni low) values:
- All outputs 0; FSM in IDLE; counters 0; RR pointer 0; output buffer empty.

FSM states: IDLE, ARB, XFER, DONE.
- IDLE: on start_i, latch len_i into rem[i] (masked-off channels load 0) and go to ARB. busy_o=1 from the next cycle.
- ARB (one cycle):
  - Pick the first i in rr_ptr, rr_ptr+1, ... (mod N_CH) with rem[i]!=0.
  - Set grant=i, burst_cnt=BURST, go to XFER.
  - If no channel has rem!=0, go to DONE.
- XFER:
  - in_ready_o[grant] = buffer_free && enable_i; every other in_ready_o is 0.
  - On handshake: rem[grant]--, burst_cnt--.
  - Leave XFER for ARB when rem[grant] reaches 0 or burst_cnt reaches 0. rr_ptr = grant+1 (wraps N_CH-1 to 0).
  - A granted channel with valid low keeps its grant; the block stalls and does not skip the channel.
- DONE:
  - Wait until the output buffer is empty, then pulse done_o for 1 cycle, clear busy_o, go to IDLE.

Output buffer:
- Single-entry register. Latency input handshake to out_valid_o = 1 cycle.
- buffer_free = !out_valid_o || out_ready_i, which gives full throughput of 1 beat/cycle.
- out_tag_o = grant. out_last_o = 1 when the accepted beat made rem[grant] go 1 to 0.
- out_data_o, out_tag_o, out_last_o are stable while out_valid_o && !out_ready_i.

Boundary conditions:
- start_i while busy_o is ignored.
- All lens 0 or mask 0: IDLE -> ARB -> DONE; done_o asserts 3 cycles after start_i, with no output beats.
- len=0 channel: never granted.
- BURST >= len: the channel drains in one turn.
- clear_i (priority over start_i): next cycle FSM is IDLE, buffer empty, rem/rr_ptr zeroed, done_o not asserted. Applies mid-XFER.
- enable_i low:
  - in_ready_o all 0 and no FSM transitions.
  - out_valid_o and buffered data held; an out_ready_i handshake is not taken.
- Async reset mid-operation: immediate return to reset values.
- Counters do not wrap: rem decrements only on handshake, and only while rem!=0.

Optional Feature:
Macro MULTI_DATAFLOW_SCHED_PERF_EN.
- Defined: perf_stall_o counts cycles with out_valid_o && !out_ready_i && enable_i.
  - Resets to 0 on rst_ni, clear_i, or an accepted start_i.
  - Saturates at 2^32-1.
- Undefined: the counter logic is not compiled in; perf_stall_o is tied to 0.

Test Plan:
- N_CH=2, BURST=4, len={6,3}, mask=11, all valid, out_ready=1 -> output tags 0,0,0,0,1,1,1,0,0; out_last on beats 7 and 9; done_o exactly once; busy_o low afterwards.
- len={0,0}, mask=11, start -> no out_valid_o; done_o pulse 3 cycles after start.
- len={5,5}, mask=10 -> only channel 1 gets in_ready_o; 5 beats all with tag 1; channel 0 never readied.
- out_ready_i toggling 1,0,1,0 during a 4-beat burst -> data and tag stable through stalls, no beat lost or duplicated; with PERF_EN, perf_stall_o = number of stall cycles (2).
- clear_i asserted after 3 of 8 beats -> next cycle busy_o=0, out_valid_o=0, all in_ready_o=0, no done_o; a new start with len={2,2} completes with 4 beats.
- Grant on channel 0 with in_valid_i[0] held low 10 cycles while channel 1 is valid -> no beats forwarded and channel 1 never readied; transfer resumes when in_valid_i[0] rises.

Source files
------------

// File: rtl/multi_dataflow_stream_sched.sv
// ---------------------------------------------------------------------------
// multi_dataflow_stream_sched
//
// N-channel input scheduler between the multi_dataflow streamer and the
// engine. Merges N_CH valid/ready source streams into one sink stream using
// round-robin arbitration that grants up to BURST consecutive beats per turn.
// Each channel transfers a programmed number of beats (len_i, sampled on
// start_i). Beats are tagged with their channel index, the final beat of each
// channel is flagged, and done_o pulses once every enabled channel drains.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              synchronous soft clear (wins over start_i)
//   enable_i             global enable; low freezes all state
//   start_i              start pulse; samples len_i / ch_mask_i in IDLE
//   len_i, ch_mask_i     per-channel beat counts and channel enable mask
//   in_data_i/valid_i    per-channel source streams
//   in_ready_o           per-channel ready (only the granted channel)
//   out_data_o/tag_o/last_o/valid_o, out_ready_i   merged sink stream
//   busy_o, done_o       job status and one-cycle completion pulse
//   perf_stall_o         back-pressure cycle counter
//
// Optional feature: define MULTI_DATAFLOW_SCHED_PERF_EN to build the
// saturating back-pressure counter; otherwise perf_stall_o is tied to 0.
// ---------------------------------------------------------------------------

// Per-channel remaining-beat counter. Never wraps below zero.
module multi_dataflow_stream_sched_ch #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear,
    input  logic                 en,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 dec,
    output logic [CNT_WIDTH-1:0] rem
);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem <= '0;
        end else if (clear) begin
            rem <= '0;
        end else if (en) begin
            if (load)
                rem <= load_val;
            else if (dec && (rem != '0))
                rem <= rem - 1'b1;
        end
    end
endmodule

module multi_dataflow_stream_sched #(
    parameter int N_CH       = 2,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int BURST      = 4,
    localparam int TAG_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       enable_i,
    input  logic                       start_i,
    input  logic [N_CH*CNT_WIDTH-1:0]  len_i,
    input  logic [N_CH-1:0]            ch_mask_i,
    input  logic [N_CH*DATA_WIDTH-1:0] in_data_i,
    input  logic [N_CH-1:0]            in_valid_i,
    output logic [N_CH-1:0]            in_ready_o,
    output logic [DATA_WIDTH-1:0]      out_data_o,
    output logic [TAG_W-1:0]           out_tag_o,
    output logic                       out_last_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [31:0]                perf_stall_o
);
    localparam int BCW = $clog2(BURST + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_XFER, S_DONE} state_t;

    state_t                             state, state_nxt;
    logic [TAG_W-1:0]                   grant, rr_ptr, arb_idx;
    logic [BCW-1:0]                     burst_cnt;
    logic [N_CH-1:0][CNT_WIDTH-1:0]     rem;
    logic [N_CH-1:0]                    rem_nz;
    logic [CNT_WIDTH-1:0]               rem_sel;
    logic [DATA_WIDTH-1:0]              data_sel;
    logic                               arb_hit, buffer_free, hs;
    logic                               start_ok, leave_xfer, done_nxt;

    assign buffer_free = !out_valid_o || out_ready_i;
    assign start_ok    = (state == S_IDLE) && start_i && enable_i && !clear_i;
    assign busy_o      = (state != S_IDLE);

    // Per-channel beat counters; masked-off channels load 0 and are never granted.
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        multi_dataflow_stream_sched_ch #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .clear    (clear_i),
            .en       (enable_i),
            .load     (start_ok),
            .load_val (ch_mask_i[g] ? len_i[g*CNT_WIDTH +: CNT_WIDTH] : '0),
            .dec      (hs && (grant == TAG_W'(g))),
            .rem      (rem[g])
        );
        assign rem_nz[g] = (rem[g] != '0);
    end

    // Granted-channel muxes.
    always_comb begin
        rem_sel  = '0;
        data_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant == TAG_W'(i)) begin
                rem_sel  = rem[i];
                data_sel = in_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Round-robin search starting at rr_ptr for the first channel with work left.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % N_CH;
            if (!arb_hit && rem_nz[idx]) begin
                arb_hit = 1'b1;
                arb_idx = TAG_W'(idx);
            end
        end
    end

    // Only the granted channel is readied; an idle-valid grant stalls rather than skips.
    always_comb begin
        in_ready_o = '0;
        for (int i = 0; i < N_CH; i++)
            in_ready_o[i] = (state == S_XFER) && (grant == TAG_W'(i)) && buffer_free && enable_i;
    end

    assign hs         = |(in_ready_o & in_valid_i);
    assign leave_xfer = hs && ((rem_sel == CNT_WIDTH'(1)) || (burst_cnt == BCW'(1)));

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: if (start_i) state_nxt = S_ARB;
            S_ARB:  state_nxt = arb_hit ? S_XFER : S_DONE;
            S_XFER: if (leave_xfer) state_nxt = S_ARB;
            S_DONE: begin
                // Hold completion until the last beat has left the buffer.
                if (!out_valid_o) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= S_IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            done_o    <= 1'b0;
        end else if (clear_i) begin
            state     <= S_IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            done_o    <= 1'b0;
        end else begin
            done_o <= enable_i && done_nxt;
            if (enable_i) begin
                state <= state_nxt;
                if ((state == S_ARB) && arb_hit) begin
                    grant     <= arb_idx;
                    burst_cnt <= BCW'(BURST);
                end
                if ((state == S_XFER) && hs) begin
                    burst_cnt <= burst_cnt - 1'b1;
                    if (leave_xfer)
                        rr_ptr <= (grant == TAG_W'(N_CH - 1)) ? '0 : grant + 1'b1;
                end
            end
        end
    end

    // Single-entry output buffer: loads on input handshake, drains on out_ready_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_tag_o   <= '0;
            out_last_o  <= 1'b0;
        end else if (clear_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_tag_o   <= '0;
            out_last_o  <= 1'b0;
        end else if (enable_i) begin
            if (hs) begin
                out_valid_o <= 1'b1;
                out_data_o  <= data_sel;
                out_tag_o   <= grant;
                out_last_o  <= (rem_sel == CNT_WIDTH'(1));
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

`ifdef MULTI_DATAFLOW_SCHED_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            stall_cnt <= '0;
        else if (clear_i || start_ok)
            stall_cnt <= '0;
        else if (out_valid_o && !out_ready_i && enable_i && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign perf_stall_o = stall_cnt;
`else
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_multi_dataflow_stream_sched.sv
module tb_multi_dataflow_stream_sched;
    localparam int N_CH = 2;
    localparam int DW   = 32;
    localparam int CW   = 16;

    logic              clk_i = 1'b0;
    logic              rst_ni, clear_i, enable_i, start_i;
    logic [N_CH*CW-1:0] len_i;
    logic [N_CH-1:0]   ch_mask_i;
    logic [N_CH*DW-1:0] in_data_i;
    logic [N_CH-1:0]   in_valid_i, in_ready_o;
    logic [DW-1:0]     out_data_o;
    logic              out_tag_o, out_last_o, out_valid_o, out_ready_i;
    logic              busy_o, done_o;
    logic [31:0]       perf_stall_o;

    multi_dataflow_stream_sched #(.N_CH(N_CH), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .BURST(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i),
        .start_i(start_i), .len_i(len_i), .ch_mask_i(ch_mask_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .out_data_o(out_data_o), .out_tag_o(out_tag_o), .out_last_o(out_last_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .busy_o(busy_o), .done_o(done_o), .perf_stall_o(perf_stall_o)
    );

    always #5 clk_i = ~clk_i;

    int          total = 0;
    int          bad   = 0;
    logic [33:0] got[$];
    logic [33:0] expq[$];
    int          done_cnt;
    logic [1:0]  rdy_seen;
    logic [7:0]  seq[2];
    logic        prev_stall;
    logic [33:0] prev_beat;
    logic [33:0] held;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Source data encodes channel and per-channel sequence number.
    task automatic drive_data();
        for (int c = 0; c < N_CH; c++)
            in_data_i[c*DW +: DW] = {16'h0, 8'(c), seq[c]};
    endtask

    function automatic logic [33:0] bt(input logic tag, input logic [7:0] s, input logic last);
        return {last, tag, 16'h0, 7'h0, tag, s};
    endfunction

    // One clock: observe at the falling edge, advance sources after the rising edge.
    task automatic tick();
        logic [1:0] hs;
        @(negedge clk_i);
        hs = in_valid_i & in_ready_o;
        rdy_seen = rdy_seen | in_ready_o;
        if (done_o) done_cnt++;
        if (prev_stall)
            check("hold", {out_valid_o, out_last_o, out_tag_o, out_data_o}, {1'b1, prev_beat});
        prev_stall = out_valid_o && !out_ready_i && enable_i;
        prev_beat  = {out_last_o, out_tag_o, out_data_o};
        if (out_valid_o && out_ready_i && enable_i)
            got.push_back({out_last_o, out_tag_o, out_data_o});
        @(posedge clk_i);
        #1;
        for (int c = 0; c < N_CH; c++)
            if (hs[c]) seq[c]++;
        drive_data();
    endtask

    task automatic run_to_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        check("done_seen", 64'(done_cnt != 0), 64'd1);
    endtask

    task automatic cmp_beats(input string name);
        check({name, "_count"}, 64'(got.size()), 64'(expq.size()));
        for (int i = 0; i < got.size() && i < expq.size(); i++)
            check(name, 64'(got[i]), 64'(expq[i]));
    endtask

    task automatic start_job(input logic [15:0] l0, input logic [15:0] l1, input logic [1:0] m);
        got.delete();
        expq.delete();
        done_cnt = 0;
        rdy_seen = '0;
        seq[0] = 8'd0;
        seq[1] = 8'd0;
        drive_data();
        len_i     = {l1, l0};
        ch_mask_i = m;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0; clear_i = 1'b0; enable_i = 1'b1; start_i = 1'b0;
        len_i = '0; ch_mask_i = '0; in_valid_i = '0; out_ready_i = 1'b0;
        seq[0] = 8'd0; seq[1] = 8'd0; prev_stall = 1'b0; prev_beat = '0;
        done_cnt = 0; rdy_seen = '0;
        drive_data();
        #2;
        check("rst_busy", 64'(busy_o), 0);
        check("rst_valid", 64'(out_valid_o), 0);
        check("rst_done", 64'(done_o), 0);
        check("rst_ready", 64'(in_ready_o), 0);
        check("rst_perf", 64'(perf_stall_o), 0);
        check("rst_beat", {out_last_o, out_tag_o, out_data_o}, 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        tick();

        // Round-robin with burst 4: ch0 x4, ch1 x3, ch0 x2; mid-job start ignored.
        in_valid_i = 2'b11;
        out_ready_i = 1'b1;
        start_job(16'd6, 16'd3, 2'b11);
        check("t1_busy_on", 64'(busy_o), 1);
        tick();
        len_i = {16'd9, 16'd9};
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        run_to_done(60);
        for (int i = 0; i < 4; i++) expq.push_back(bt(1'b0, 8'(i), 1'b0));
        for (int i = 0; i < 3; i++) expq.push_back(bt(1'b1, 8'(i), i == 2));
        expq.push_back(bt(1'b0, 8'd4, 1'b0));
        expq.push_back(bt(1'b0, 8'd5, 1'b1));
        check("t1_busy_at_done", 64'(busy_o), 0);
        tick();
        tick();
        cmp_beats("t1_beat");
        check("t1_done_once", 64'(done_cnt), 1);
        check("t1_busy_off", 64'(busy_o), 0);

        // All lengths zero: done pulse exactly 3 cycles after start.
        start_job(16'd0, 16'd0, 2'b11);
        check("t2_done_c1", 64'(done_o), 0);
        check("t2_busy_c1", 64'(busy_o), 1);
        tick();
        check("t2_done_c2", 64'(done_o), 0);
        tick();
        check("t2_done_c3", 64'(done_o), 1);
        check("t2_busy_c3", 64'(busy_o), 0);
        tick();
        check("t2_done_c4", 64'(done_o), 0);
        check("t2_no_beats", 64'(got.size()), 0);

        // Mask 10: only channel 1 transfers, in two turns.
        start_job(16'd5, 16'd5, 2'b10);
        run_to_done(40);
        for (int i = 0; i < 5; i++) expq.push_back(bt(1'b1, 8'(i), i == 4));
        cmp_beats("t3_beat");
        check("t3_ch0_never_ready", 64'(rdy_seen[0]), 0);

        // Sink back-pressure 1,0,1,0 during a 4-beat burst.
        start_job(16'd4, 16'd0, 2'b01);
        tick();
        tick();
        tick(); out_ready_i = 1'b0;
        tick(); out_ready_i = 1'b1;
        tick(); out_ready_i = 1'b0;
        tick(); out_ready_i = 1'b1;
        run_to_done(30);
        for (int i = 0; i < 4; i++) expq.push_back(bt(1'b0, 8'(i), i == 3));
        cmp_beats("t4_beat");
`ifdef MULTI_DATAFLOW_SCHED_PERF_EN
        check("t4_perf", 64'(perf_stall_o), 2);
`else
        check("t4_perf", 64'(perf_stall_o), 0);
`endif

        // Soft clear after 3 of 8 beats, asserted together with start.
        begin
            int n;
            start_job(16'd4, 16'd4, 2'b11);
            n = 0;
            while (got.size() < 3 && n < 30) begin
                tick();
                n++;
            end
            check("t5_three_beats", 64'(got.size()), 3);
            clear_i = 1'b1;
            start_i = 1'b1;
            tick();
            clear_i = 1'b0;
            start_i = 1'b0;
            check("t5_busy", 64'(busy_o), 0);
            check("t5_valid", 64'(out_valid_o), 0);
            check("t5_ready", 64'(in_ready_o), 0);
            check("t5_done", 64'(done_o), 0);
            check("t5_perf", 64'(perf_stall_o), 0);
            tick();
            tick();
            tick();
            check("t5_no_done", 64'(done_cnt), 0);
            check("t5_still_idle", 64'(busy_o), 0);
        end
        start_job(16'd2, 16'd2, 2'b11);
        run_to_done(30);
        expq.push_back(bt(1'b0, 8'd0, 1'b0));
        expq.push_back(bt(1'b0, 8'd1, 1'b1));
        expq.push_back(bt(1'b1, 8'd0, 1'b0));
        expq.push_back(bt(1'b1, 8'd1, 1'b1));
        cmp_beats("t5_beat");

        // Granted channel 0 idle for 10 cycles: block stalls, channel 1 untouched.
        in_valid_i = 2'b10;
        start_job(16'd2, 16'd2, 2'b11);
        repeat (11) tick();
        check("t6_no_beats", 64'(got.size()), 0);
        check("t6_ch1_never_ready", 64'(rdy_seen[1]), 0);
        check("t6_busy", 64'(busy_o), 1);
        in_valid_i = 2'b11;
        run_to_done(30);
        expq.push_back(bt(1'b0, 8'd0, 1'b0));
        expq.push_back(bt(1'b0, 8'd1, 1'b1));
        expq.push_back(bt(1'b1, 8'd0, 1'b0));
        expq.push_back(bt(1'b1, 8'd1, 1'b1));
        cmp_beats("t6_beat");

        // Enable low freezes the block, buffered beat held and not consumed.
        start_job(16'd3, 16'd0, 2'b01);
        tick();
        tick();
        enable_i = 1'b0;
        #1;
        check("t7_ready_off", 64'(in_ready_o), 0);
        check("t7_valid_held", 64'(out_valid_o), 1);
        held = {out_last_o, out_tag_o, out_data_o};
        tick();
        tick();
        check("t7_beat_held", {out_last_o, out_tag_o, out_data_o}, held);
        check("t7_valid_still", 64'(out_valid_o), 1);
        check("t7_busy", 64'(busy_o), 1);
        enable_i = 1'b1;
        run_to_done(30);
        for (int i = 0; i < 3; i++) expq.push_back(bt(1'b0, 8'(i), i == 2));
        cmp_beats("t7_beat");

        // Asynchronous reset in the middle of a transfer.
        start_job(16'd4, 16'd4, 2'b11);
        tick();
        tick();
        tick();
        rst_ni = 1'b0;
        #1;
        check("t8_busy", 64'(busy_o), 0);
        check("t8_valid", 64'(out_valid_o), 0);
        check("t8_ready", 64'(in_ready_o), 0);
        prev_stall = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
